vc_alloc_ctl: RTL and testbench

//  Clocked virtual-channel allocator for one router output port.

---
 rtl/vca_pkg.sv | 25 ++
 rtl/rr_arb.sv | 46 ++++
 rtl/vc_alloc_ctl.sv | 109 ++++++++++
 tb/tb_vc_alloc_ctl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vca_pkg.sv
// Shared types and helpers for the virtual-channel allocator.
//  MAX_R     : largest requester count the owner index can encode
//  IDX_W     : width of a requester index (owner registers, RR pointer)
//  owner_t   : per-output-VC ownership record {valid, idx}
//  onehot2idx: converts a one-hot requester vector to its index
package vca_pkg;

    localparam int MAX_R = 32;
    localparam int IDX_W = $clog2(MAX_R);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } owner_t;

    function automatic logic [IDX_W-1:0] onehot2idx(input logic [MAX_R-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_R; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker.
//  req     in  N      candidate requests
//  ptr     in  IDX_W  highest-priority position (must be < N)
//  win     out N      one-hot winner (zero when no request)
//  win_idx out IDX_W  index of the winner
//  any     out 1      at least one request present
module rr_arb
    import vca_pkg::*;
#(
    parameter int N = 10
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     win,
    output logic [IDX_W-1:0] win_idx,
    output logic             any
);

    logic [MAX_R-1:0] win_ext;
    logic             found;

    // Scan N positions starting at ptr, wrapping N-1 -> 0; first hit wins.
    always_comb begin
        int j;
        win   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                win[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        win_ext        = '0;
        win_ext[N-1:0] = win;
    end

    assign win_idx = onehot2idx(win_ext);
    assign any     = |req;

endmodule

// File: rtl/vc_alloc_ctl.sv
// Virtual-channel allocator for one router output port.
// Shares VCN output VCs among R = PN*VCN input VCs with round-robin fairness;
// at most one new allocation per cycle; an owner holds its VC until it
// pulses rel (tail flit sent).
//  clk      in   1        clock, rising edge
//  rstn     in   1        asynchronous active-low reset
//  req      in   R        requester wants an output VC (level)
//  rel      in   R        owner frees its VC (1-cycle pulse)
//  gnt      out  R        allocation made to requester i (1-cycle pulse)
//  gvc      out  R*VCN    bit i*VCN+v set while requester i owns VC v
//  vc_busy  out  VCN      output VC currently owned
//  err      out  1        rel from a requester that owns nothing (pulse)
module vc_alloc_ctl
    import vca_pkg::*;
#(
    parameter  int VCN = 2,
    parameter  int PN  = 5,
    localparam int R   = PN * VCN
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [R-1:0]     req,
    input  logic [R-1:0]     rel,
    output logic [R-1:0]     gnt,
    output logic [R*VCN-1:0] gvc,
    output logic [VCN-1:0]   vc_busy,
    output logic             err
);

    owner_t           owner_q [VCN];
    logic [IDX_W-1:0] ptr_q;

    logic [R-1:0]     own_any;
    logic [R-1:0]     eligible;
    logic [VCN-1:0]   rel_hit;
    logic             free_found;
    int               free_v;
    logic [R-1:0]     win;
    logic [IDX_W-1:0] win_idx;
    logic             any_elig;
    logic             do_alloc;
    logic [IDX_W-1:0] ptr_nxt;
    logic             err_nxt;

    // Ownership views are decoded straight from the owner registers, so
    // gvc/vc_busy have no path from req/rel.
    always_comb begin
        own_any    = '0;
        gvc        = '0;
        vc_busy    = '0;
        rel_hit    = '0;
        free_found = 1'b0;
        free_v     = 0;
        for (int v = 0; v < VCN; v++) begin
            vc_busy[v] = owner_q[v].valid;
            if (owner_q[v].valid) begin
                own_any[int'(owner_q[v].idx)]          = 1'b1;
                gvc[int'(owner_q[v].idx) * VCN + v]    = 1'b1;
                rel_hit[v]                             = rel[int'(owner_q[v].idx)];
            end else if (!free_found) begin
                free_v     = v;
                free_found = 1'b1;
            end
        end
    end

    // A requester that already owns a VC (including one releasing this cycle)
    // is not eligible, so it can never hold two VCs.
    assign eligible = req & ~own_any;
    assign err_nxt  = |(rel & ~own_any);

    rr_arb #(
        .N (R)
    ) u_arb (
        .req     (eligible),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx),
        .any     (any_elig)
    );

    // A VC released this cycle still reads busy, so it is not reused until
    // the cycle after vc_busy falls.
    assign do_alloc = free_found && any_elig;
    assign ptr_nxt  = (int'(win_idx) == R - 1) ? '0 : win_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            gnt   <= '0;
            err   <= 1'b0;
            ptr_q <= '0;
            for (int v = 0; v < VCN; v++) owner_q[v] <= '0;
        end else begin
            gnt <= do_alloc ? win : '0;
            err <= err_nxt;
            if (do_alloc) ptr_q <= ptr_nxt;
            // Release only touches owned VCs, allocation only a free one,
            // so the two never target the same entry.
            for (int v = 0; v < VCN; v++) begin
                if (rel_hit[v]) begin
                    owner_q[v].valid <= 1'b0;
                end else if (do_alloc && free_v == v) begin
                    owner_q[v] <= '{valid: 1'b1, idx: win_idx};
                end
            end
        end
    end

endmodule

// File: tb/tb_vc_alloc_ctl.sv
module tb_vc_alloc_ctl;

    localparam int VCN = 2;
    localparam int PN  = 5;
    localparam int R   = PN * VCN;

    logic             clk = 1'b0;
    logic             rstn;
    logic [R-1:0]     req;
    logic [R-1:0]     rel;
    logic [R-1:0]     gnt;
    logic [R*VCN-1:0] gvc;
    logic [VCN-1:0]   vc_busy;
    logic             err;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns each output VC (-1 = free) and the RR pointer.
    int owner_m [VCN];
    int ptr_m;

    vc_alloc_ctl #(.VCN(VCN), .PN(PN)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gvc     (gvc),
        .vc_busy (vc_busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    function automatic logic [R-1:0] bitv(input int i);
        logic [R-1:0] b;
        b    = '0;
        b[i] = 1'b1;
        return b;
    endfunction

    function automatic bit owns_m(input int i);
        for (int v = 0; v < VCN; v++) if (owner_m[v] == i) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int v = 0; v < VCN; v++) owner_m[v] = -1;
        ptr_m = 0;
    endtask

    // One clock: drive inputs, advance the model by the allocation rules,
    // then compare all outputs just after the edge.
    task automatic cycle(input logic [R-1:0] rq, input logic [R-1:0] rl);
        int               free_v;
        int               win;
        int               idx;
        logic [R-1:0]     g_exp;
        logic             e_exp;
        logic [VCN-1:0]   b_exp;
        logic [R*VCN-1:0] gv_exp;
        req = rq;
        rel = rl;
        e_exp = 1'b0;
        for (int i = 0; i < R; i++) if (rl[i] && !owns_m(i)) e_exp = 1'b1;
        free_v = -1;
        for (int v = 0; v < VCN; v++) if (owner_m[v] < 0 && free_v < 0) free_v = v;
        win = -1;
        for (int k = 0; k < R; k++) begin
            idx = (ptr_m + k) % R;
            if (win < 0 && rq[idx] && !owns_m(idx)) win = idx;
        end
        for (int v = 0; v < VCN; v++)
            if (owner_m[v] >= 0 && rl[owner_m[v]]) owner_m[v] = -1;
        g_exp = '0;
        if (free_v >= 0 && win >= 0) begin
            owner_m[free_v] = win;
            ptr_m           = (win + 1) % R;
            g_exp[win]      = 1'b1;
        end
        @(posedge clk);
        #1;
        b_exp  = '0;
        gv_exp = '0;
        for (int v = 0; v < VCN; v++) begin
            if (owner_m[v] >= 0) begin
                b_exp[v]                    = 1'b1;
                gv_exp[owner_m[v] * VCN + v] = 1'b1;
            end
        end
        checks++;
        if (gnt !== g_exp) begin
            errors++;
            $display("FAIL model_gnt t=%0t got=%b exp=%b", $time, gnt, g_exp);
        end
        checks++;
        if (err !== e_exp) begin
            errors++;
            $display("FAIL model_err t=%0t got=%b exp=%b", $time, err, e_exp);
        end
        checks++;
        if (vc_busy !== b_exp) begin
            errors++;
            $display("FAIL model_busy t=%0t got=%b exp=%b", $time, vc_busy, b_exp);
        end
        checks++;
        if (gvc !== gv_exp) begin
            errors++;
            $display("FAIL model_gvc t=%0t got=%b exp=%b", $time, gvc, gv_exp);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req  = '1;
        rel  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL reset_gnt got=%b exp=0", gnt); end
        checks++;
        if (gvc !== '0) begin errors++; $display("FAIL reset_gvc got=%b exp=0", gvc); end
        checks++;
        if (vc_busy !== '0) begin errors++; $display("FAIL reset_busy got=%b exp=0", vc_busy); end
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        @(negedge clk);
        rstn = 1'b1;
        cycle('1, '0);
        checks++;
        if (gnt !== bitv(0)) begin errors++; $display("FAIL reset_first_gnt got=%b exp=%b", gnt, bitv(0)); end
        cycle('1, '0);
        checks++;
        if (gnt !== bitv(1)) begin errors++; $display("FAIL reset_second_gnt got=%b exp=%b", gnt, bitv(1)); end
        cycle('0, bitv(0) | bitv(1));
        cycle('0, '0);
    endtask

    task automatic test_rr_fairness();
        logic [R-1:0] rq;
        // Single grant to 3 leaves ptr at 4, then free it again.
        cycle(bitv(3), '0);
        cycle('0, bitv(3));
        cycle('0, '0);
        rq = bitv(3) | bitv(7) | bitv(9);
        cycle(rq, '0);
        checks++;
        if (gnt !== bitv(7)) begin errors++; $display("FAIL rr_first got=%b exp=%b", gnt, bitv(7)); end
        checks++;
        if (gvc[7*VCN +: VCN] !== 2'b01) begin errors++; $display("FAIL rr_gvc7 got=%b exp=01", gvc[7*VCN +: VCN]); end
        cycle(rq, '0);
        checks++;
        if (gnt !== bitv(9)) begin errors++; $display("FAIL rr_second got=%b exp=%b", gnt, bitv(9)); end
        checks++;
        if (gvc[9*VCN +: VCN] !== 2'b10) begin errors++; $display("FAIL rr_gvc9 got=%b exp=10", gvc[9*VCN +: VCN]); end
        checks++;
        if (vc_busy !== 2'b11) begin errors++; $display("FAIL rr_busy got=%b exp=11", vc_busy); end
        cycle(bitv(3), '0);
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL rr_waits got=%b exp=0", gnt); end
    endtask

    task automatic test_full_free();
        cycle(bitv(3), bitv(7));
        checks++;
        if (vc_busy !== 2'b10) begin errors++; $display("FAIL free_busy got=%b exp=10", vc_busy); end
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL free_no_reuse got=%b exp=0", gnt); end
        cycle(bitv(3), '0);
        checks++;
        if (gnt !== bitv(3)) begin errors++; $display("FAIL free_gnt3 got=%b exp=%b", gnt, bitv(3)); end
        checks++;
        if (gvc[3*VCN +: VCN] !== 2'b01) begin errors++; $display("FAIL free_gvc3 got=%b exp=01", gvc[3*VCN +: VCN]); end
        cycle('0, bitv(3) | bitv(9));
        cycle('0, '0);
    endtask

    task automatic test_wrap();
        // Grant to 8 leaves ptr at 9.
        cycle(bitv(8), '0);
        cycle('0, bitv(8));
        cycle('0, '0);
        cycle(bitv(9) | bitv(2), '0);
        checks++;
        if (gnt !== bitv(9)) begin errors++; $display("FAIL wrap_first got=%b exp=%b", gnt, bitv(9)); end
        cycle(bitv(2), '0);
        checks++;
        if (gnt !== bitv(2)) begin errors++; $display("FAIL wrap_second got=%b exp=%b", gnt, bitv(2)); end
    endtask

    task automatic test_simultaneous();
        // 9 owns VC0, 2 owns VC1.
        cycle(bitv(9), bitv(9));
        checks++;
        if (gnt !== '0) begin errors++; $display("FAIL simul_no_gnt got=%b exp=0", gnt); end
        checks++;
        if (vc_busy !== 2'b10) begin errors++; $display("FAIL simul_busy got=%b exp=10", vc_busy); end
        cycle(bitv(9), '0);
        checks++;
        if (gnt !== bitv(9)) begin errors++; $display("FAIL simul_regnt got=%b exp=%b", gnt, bitv(9)); end
        cycle('0, bitv(4));
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_pulse got=%b exp=1", err); end
        checks++;
        if (vc_busy !== 2'b11) begin errors++; $display("FAIL err_state got=%b exp=11", vc_busy); end
        cycle('0, '0);
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got=%b exp=0", err); end
    endtask

    task automatic test_reset_mid();
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (gvc !== '0) begin errors++; $display("FAIL mid_gvc got=%b exp=0", gvc); end
        checks++;
        if (vc_busy !== '0) begin errors++; $display("FAIL mid_busy got=%b exp=0", vc_busy); end
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        cycle('1, '0);
        checks++;
        if (gnt !== bitv(0)) begin errors++; $display("FAIL mid_first got=%b exp=%b", gnt, bitv(0)); end
        cycle('1, '0);
        checks++;
        if (gnt !== bitv(1)) begin errors++; $display("FAIL mid_second got=%b exp=%b", gnt, bitv(1)); end
    endtask

    task automatic test_random();
        logic [R-1:0] rq;
        logic [R-1:0] rl;
        for (int n = 0; n < 400; n++) begin
            rq = '0;
            rl = '0;
            for (int i = 0; i < R; i++) begin
                rq[i] = ($urandom_range(0, 2) != 0);
                if (owns_m(i)) rl[i] = ($urandom_range(0, 3) == 0);
                else           rl[i] = ($urandom_range(0, 19) == 0);
            end
            cycle(rq, rl);
        end
    endtask

    initial begin
        req  = '0;
        rel  = '0;
        rstn = 1'b0;
        test_reset();
        test_rr_fairness();
        test_full_free();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
